// File: rtl/mem_arbiter_unified_pkg.sv
// Shared types and constants for the unified memory arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_arbiter_unified_pkg;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_INST = 2'd2,
        ST_RESP = 2'd3
    } arb_state_t;

    // Read data returned when an access is force-completed by the timeout
    localparam logic TMO_RDATA_BIT = 1'b0;

    // Default widths and behaviour
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT_CYC = 255;
    localparam int DEF_DATA_FIRST  = 1;

    // Counter width able to hold 0 .. limit-1
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Wait-cycle counter that flags expiry after LIMIT enabled cycles; LIMIT=0 never expires.
// Latency: expired is combinational in the LIMIT-th consecutive enabled cycle.
// Backpressure: none; clr has priority over en.
module mem_timeout_cnt
    import mem_arbiter_unified_pkg::*;
#(
    parameter int LIMIT = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    generate
        if (LIMIT > 0) begin : g_cnt
            localparam int CNT_W = cnt_width(LIMIT);
            localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

            logic [CNT_W-1:0] cnt;

            // Count enabled cycles, restart on clear
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt <= '0;
                end else if (clr) begin
                    cnt <= '0;
                end else if (en) begin
                    cnt <= cnt + 1'b1;
                end
            end

            // The cycle that would be the LIMIT-th wait cycle is the expiry cycle
            assign expired = en && (cnt == LAST);
        end else begin : g_off
            assign expired = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/mem_arbiter_unified.sv
// Serialises core fetch and data accesses onto one req/ack memory port, with timeout.
// Latency: 1 IDLE cycle + wait cycles per access + 1 RESP cycle; back-to-back accesses share no gap.
// Backpressure: stalls the core via stallreq_o; mem_req_o is held until mem_ack_i or timeout.
module mem_arbiter_unified
    import mem_arbiter_unified_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SEL_W       = DATA_W / 8,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int DATA_FIRST  = DEF_DATA_FIRST
) (
    input  logic              clk,
    input  logic              rst,
    // core fetch side
    input  logic              rom_ce_i,
    input  logic [ADDR_W-1:0] rom_addr_i,
    output logic [DATA_W-1:0] rom_data_o,
    // core data side
    input  logic              ram_ce_i,
    input  logic              ram_we_i,
    input  logic [ADDR_W-1:0] ram_addr_i,
    input  logic [SEL_W-1:0]  ram_sel_i,
    input  logic [DATA_W-1:0] ram_data_i,
    output logic [DATA_W-1:0] ram_data_o,
    // pipeline control
    output logic              stallreq_o,
    output logic              bus_err_o,
    // memory port
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [SEL_W-1:0]  mem_sel_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam bit DATA_PRIO = (DATA_FIRST != 0);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic              data_pend_q;
    logic              inst_pend_q;
    logic              data_done_q;
    logic              inst_done_q;
    logic              busy;
    logic              tmo_exp;
    logic              cmpl;
    logic [DATA_W-1:0] rd_val;

    assign busy   = (state_q == ST_DATA) || (state_q == ST_INST);
    // A timeout completes the access exactly like an ack, but with fixed read data
    assign cmpl   = busy && (mem_ack_i || tmo_exp);
    assign rd_val = mem_ack_i ? mem_rdata_i : {DATA_W{TMO_RDATA_BIT}};

    mem_timeout_cnt #(
        .LIMIT (TIMEOUT_CYC)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (cmpl || !busy),
        .en      (busy),
        .expired (tmo_exp)
    );

    // State register; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: requests are latched in IDLE; late rises are ignored until the next IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ram_ce_i && (DATA_PRIO || !rom_ce_i)) begin
                    state_d = ST_DATA;
                end else if (rom_ce_i) begin
                    state_d = ST_INST;
                end
            end
            ST_DATA: begin
                if (cmpl) begin
                    state_d = (inst_pend_q && rom_ce_i && !inst_done_q) ? ST_INST : ST_RESP;
                end
            end
            ST_INST: begin
                if (cmpl) begin
                    state_d = (data_pend_q && ram_ce_i && !data_done_q) ? ST_DATA : ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: memory port mirrors the selected core inputs; stall is killed by reset at once
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_sel_o   = '0;
        mem_wdata_o = '0;
        stallreq_o  = 1'b0;
        bus_err_o   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stallreq_o = rom_ce_i || ram_ce_i;
            end
            ST_DATA: begin
                mem_req_o   = 1'b1;
                mem_we_o    = ram_we_i;
                mem_addr_o  = ram_addr_i;
                mem_sel_o   = ram_sel_i;
                mem_wdata_o = ram_data_i;
                stallreq_o  = 1'b1;
                bus_err_o   = tmo_exp && !mem_ack_i;
            end
            ST_INST: begin
                mem_req_o  = 1'b1;
                mem_addr_o = rom_addr_i;
                mem_sel_o  = '1;
                stallreq_o = 1'b1;
                bus_err_o  = tmo_exp && !mem_ack_i;
            end
            default: begin
                stallreq_o = 1'b0;
            end
        endcase
        stallreq_o = stallreq_o && rst;
    end

    // Request snapshot and done tracking for the current pipeline cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_pend_q <= 1'b0;
            inst_pend_q <= 1'b0;
            data_done_q <= 1'b0;
            inst_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    data_pend_q <= ram_ce_i;
                    inst_pend_q <= rom_ce_i;
                end
                ST_DATA: begin
                    if (cmpl) begin
                        data_done_q <= 1'b1;
                    end
                end
                ST_INST: begin
                    if (cmpl) begin
                        inst_done_q <= 1'b1;
                    end
                end
                default: begin
                    data_pend_q <= 1'b0;
                    inst_pend_q <= 1'b0;
                    data_done_q <= 1'b0;
                    inst_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Result registers; a flushed (ce dropped) access or a write leaves them untouched
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_data_o <= '0;
            ram_data_o <= '0;
        end else if (cmpl) begin
            if (state_q == ST_DATA && ram_ce_i && !ram_we_i) begin
                ram_data_o <= rd_val;
            end
            if (state_q == ST_INST && rom_ce_i) begin
                rom_data_o <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_unified.sv
module tb_mem_arbiter_unified;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic [31:0] rom_data_o;
    logic        ram_ce_i;
    logic        ram_we_i;
    logic [31:0] ram_addr_i;
    logic [3:0]  ram_sel_i;
    logic [31:0] ram_data_i;
    logic [31:0] ram_data_o;
    logic        stallreq_o;
    logic        bus_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    int   n_chk = 0;
    int   n_err = 0;
    int   lat = 1;
    int   wait_cnt = 0;
    logic mem_dead = 1'b0;
    logic [31:0] tmp_w;
    txn_t exp_q[$];
    logic [31:0] memv [logic [31:0]];

    mem_arbiter_unified #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .SEL_W       (4),
        .TIMEOUT_CYC (4),
        .DATA_FIRST  (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_ce_i    (rom_ce_i),
        .rom_addr_i  (rom_addr_i),
        .rom_data_o  (rom_data_o),
        .ram_ce_i    (ram_ce_i),
        .ram_we_i    (ram_we_i),
        .ram_addr_i  (ram_addr_i),
        .ram_sel_i   (ram_sel_i),
        .ram_data_i  (ram_data_i),
        .ram_data_o  (ram_data_o),
        .stallreq_o  (stallreq_o),
        .bus_err_o   (bus_err_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_sel_o   (mem_sel_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (memv.exists(a)) return memv[a];
        return 32'h0;
    endfunction

    task automatic sb_check(input string tag);
        txn_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_extra"}, 64'd1, 64'd0);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, "_we"},    {63'd0, mem_we_o},    {63'd0, e.we});
        chk({tag, "_addr"},  {32'd0, mem_addr_o},  {32'd0, e.addr});
        chk({tag, "_sel"},   {60'd0, mem_sel_o},   {60'd0, e.sel});
        chk({tag, "_wdata"}, {32'd0, mem_wdata_o}, {32'd0, e.wdata});
    endtask

    // Memory model: ack after 'lat' cycles of held request; scoreboard pops at completion
    always @(negedge clk) begin
        if (mem_req_o && !mem_dead) begin
            wait_cnt = wait_cnt + 1;
            if (wait_cnt >= lat) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = mem_we_o ? 32'h0 : rd(mem_addr_o);
                sb_check("sb");
                if (mem_we_o) begin
                    tmp_w = rd(mem_addr_o);
                    for (int i = 0; i < 4; i++) begin
                        if (mem_sel_o[i]) tmp_w[8*i +: 8] = mem_wdata_o[8*i +: 8];
                    end
                    memv[mem_addr_o] = tmp_w;
                end
                wait_cnt = 0;
            end else begin
                mem_ack_i = 1'b0;
            end
        end else begin
            mem_ack_i   = 1'b0;
            mem_rdata_i = 32'h0;
            wait_cnt    = 0;
            if (bus_err_o) sb_check("sb_tmo");
        end
    end

    // One pipeline cycle: drive core requests, count stall and bus-error cycles, release in RESP
    task automatic do_op(input string tag, input logic f_ce, input logic [31:0] f_addr,
                         input logic d_ce, input logic d_we, input logic [31:0] d_addr,
                         input logic [3:0] d_sel, input logic [31:0] d_wdata,
                         input int l, input int flip_at, input int exp_stall, input int exp_berr);
        int  n;
        int  nb;
        logic ended;
        lat = l;
        if (d_ce) exp_q.push_back('{we: d_we, addr: d_addr, sel: d_sel, wdata: d_wdata});
        if (f_ce) exp_q.push_back('{we: 1'b0, addr: f_addr, sel: 4'hF, wdata: 32'h0});
        rom_ce_i   = f_ce;
        rom_addr_i = f_addr;
        ram_ce_i   = d_ce;
        ram_we_i   = d_we;
        ram_addr_i = d_addr;
        ram_sel_i  = d_sel;
        ram_data_i = d_wdata;
        n = 0;
        nb = 0;
        ended = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus_err_o) nb++;
            if (!stallreq_o) begin
                ended = 1'b1;
                break;
            end
            n++;
            if (n == flip_at) ram_ce_i = !ram_ce_i;
        end
        chk({tag, "_ended"}, {63'd0, ended}, 64'd1);
        chk({tag, "_resp_req"}, {63'd0, mem_req_o}, 64'd0);
        chk({tag, "_stall"}, 64'(n), 64'(exp_stall));
        chk({tag, "_berr"}, 64'(nb), 64'(exp_berr));
        rom_ce_i = 1'b0;
        ram_ce_i = 1'b0;
        ram_we_i = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_idle_stall"}, {63'd0, stallreq_o}, 64'd0);
        chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst        = 1'b0;
        rom_ce_i   = 1'b0;
        rom_addr_i = 32'h0;
        ram_ce_i   = 1'b0;
        ram_we_i   = 1'b0;
        ram_addr_i = 32'h0;
        ram_sel_i  = 4'h0;
        ram_data_i = 32'h0;
        mem_ack_i  = 1'b0;
        mem_rdata_i = 32'h0;
        memv[32'h0000_0010] = 32'h3401_1100;
        memv[32'h0000_0020] = 32'h2402_0005;
        memv[32'h0000_0100] = 32'hDEAD_BEEF;
        memv[32'h0000_0200] = 32'h1234_5678;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",   {63'd0, mem_req_o},  64'd0);
        chk("rst_stall", {63'd0, stallreq_o}, 64'd0);
        chk("rst_berr",  {63'd0, bus_err_o},  64'd0);
        chk("rst_rom",   {32'd0, rom_data_o}, 64'd0);
        chk("rst_ram",   {32'd0, ram_data_o}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // fetch only, ack after one wait cycle
        do_op("fetch", 1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1, 0, 2, 0);
        chk("fetch_rom", {32'd0, rom_data_o}, {32'd0, 32'h3401_1100});

        // fetch + data read, data goes first
        do_op("both", 1'b1, 32'h0000_0020, 1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0, 1, 0, 3, 0);
        chk("both_ram", {32'd0, ram_data_o}, {32'd0, 32'hDEAD_BEEF});
        chk("both_rom", {32'd0, rom_data_o}, {32'd0, 32'h2402_0005});

        // byte write with slow ack; result register untouched
        do_op("wr", 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0100, 4'b0010, 32'h0000_AB00, 3, 0, 4, 0);
        chk("wr_ram", {32'd0, ram_data_o}, {32'd0, 32'hDEAD_BEEF});

        // read back the merged word
        do_op("rdback", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0, 2, 0, 3, 0);
        chk("rdback_ram", {32'd0, ram_data_o}, {32'd0, 32'hDEAD_ABEF});

        // no ack: timeout after 4 wait cycles returns zero
        mem_dead = 1'b1;
        do_op("tmo", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0200, 4'hF, 32'h0, 1, 0, 5, 1);
        chk("tmo_ram", {32'd0, ram_data_o}, 64'd0);
        mem_dead = 1'b0;

        // data ce dropped while in flight: access completes, result discarded, fetch served
        do_op("flush", 1'b1, 32'h0000_0010, 1'b1, 1'b0, 32'h0000_0200, 4'hF, 32'h0, 3, 2, 7, 0);
        chk("flush_ram", {32'd0, ram_data_o}, 64'd0);
        chk("flush_rom", {32'd0, rom_data_o}, {32'd0, 32'h3401_1100});

        // data ce rising after IDLE is not served
        do_op("late", 1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0200, 4'hF, 32'h0, 2, 2, 3, 0);
        chk("late_rom", {32'd0, rom_data_o}, {32'd0, 32'h2402_0005});
        chk("late_ram", {32'd0, ram_data_o}, 64'd0);

        // reset while a request is outstanding
        mem_dead   = 1'b1;
        rom_ce_i   = 1'b1;
        rom_addr_i = 32'h0000_0010;
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (mem_req_o) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("arst_req_seen", {63'd0, seen}, 64'd1);
        end
        #2;
        rst = 1'b0;
        #1;
        chk("arst_req_drop",   {63'd0, mem_req_o},  64'd0);
        chk("arst_stall_drop", {63'd0, stallreq_o}, 64'd0);
        rom_ce_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        mem_dead = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_idle_req",   {63'd0, mem_req_o},  64'd0);
        chk("arst_idle_stall", {63'd0, stallreq_o}, 64'd0);
        chk("arst_rom_clr",    {32'd0, rom_data_o}, 64'd0);

        // normal service after reset
        do_op("post", 1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1, 0, 2, 0);
        chk("post_rom", {32'd0, rom_data_o}, {32'd0, 32'h3401_1100});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_unified.md
Name: mem_arbiter_unified

Overview:
- Sits between the openmips core and a single shared memory port; replaces the separate instruction-ROM/data-RAM hookup with one parametrised unified memory.
- Serialises instruction-fetch and data accesses onto one req/ack memory bus with variable latency.
- Stalls the core through stallreq_o until every pending access of the current cycle has completed.
- Adds a configurable timeout with bus-error reporting.

Parameters:
- ADDR_W, 32, address width of the CPU and memory ports
- DATA_W, 32, data width; must be a multiple of 8
- SEL_W, DATA_W/8, byte-select width
- TIMEOUT_CYC, 255, cycles without mem_ack_i before the access is force-completed; 0 disables the timeout
- DATA_FIRST, 1, 1 = data access issued before fetch when both are pending; 0 = fetch first

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- rom_ce_i  in  1  fetch request from core
- rom_addr_i  in  ADDR_W  fetch address
- rom_data_o  out  DATA_W  fetched instruction (registered)
- ram_ce_i  in  1  data request from core
- ram_we_i  in  1  1 = write, 0 = read
- ram_addr_i  in  ADDR_W  data address
- ram_sel_i  in  SEL_W  byte enables
- ram_data_i  in  DATA_W  write data
- ram_data_o  out  DATA_W  read data (registered)
- stallreq_o  out  1  stall request to pipeline control
- bus_err_o  out  1  one-cycle pulse on timeout
- mem_req_o  out  1  memory request, held until ack
- mem_we_o  out  1  memory write strobe
- mem_addr_o  out  ADDR_W  memory address
- mem_sel_o  out  SEL_W  memory byte enables; all ones for fetch
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid with ack
- mem_ack_i  in  1  one-cycle completion from memory

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all outputs 0; done flags and timeout counter cleared.
- States: IDLE, DATA, INST, RESP.
- IDLE:
  - Core requests are sampled combinationally.
  - Any ce high -> stallreq_o=1 in that same cycle.
  - Next state is DATA or INST, chosen by DATA_FIRST among the pending requests.
  - No ce high -> stallreq_o=0; remain in IDLE.
- DATA/INST:
  - mem_req_o=1; mem_* driven combinationally from the selected core inputs; stallreq_o=1.
  - On mem_ack_i:
    - latch mem_rdata_i into ram_data_o (data read) or rom_data_o (fetch); a write leaves ram_data_o unchanged;
    - set the done flag;
    - go to the other state if its ce is high and it is not yet done, else RESP.
- RESP:
  - stallreq_o=0; mem_req_o=0; done flags cleared.
  - The pipeline advances on this edge. Next state is IDLE.
- Latency:
  - Single access: 1 (IDLE) + wait cycles until ack, then 1 RESP cycle.
  - With ack arriving 1 cycle after req: single access stalls 2 cycles; fetch plus data stalls 3 cycles.
- mem_req_o falls in the cycle after ack, or moves straight to the next access. No gap cycle is required between two back-to-back accesses.
- Timeout:
  - The counter increments every cycle in DATA/INST with no ack and clears on state change.
  - Reaching TIMEOUT_CYC acts as an ack with read data 0, and bus_err_o=1 for exactly that cycle.
- A ce that drops while its access is in flight (pipeline flush):
  - the access still completes;
  - its result is discarded (destination register not updated);
  - the FSM proceeds as though the access were done.
- A ce that rises after leaving IDLE is ignored until the next IDLE.
- mem_ack_i outside DATA/INST is ignored.
- Reset asserted mid-access aborts the access immediately; mem_req_o drops asynchronously.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, DATA=2'd1, INST=2'd2, RESP=2'd3);
  - the timeout read-data constant (0);
  - the default widths.
- One sub-module is natural: mem_timeout_cnt, a parametrised counter with clear/enable inputs and an expired output.

Test Plan:
- Fetch only, rom_addr_i=32'h0000_0010, ack 1 cycle after req, rdata=32'h3401_1100 -> stallreq_o high for 2 cycles, then rom_data_o=32'h3401_1100, mem_sel_o=4'hF.
- Fetch plus data read at 32'h0000_0100, DATA_FIRST=1 -> data issued first, ram_data_o=rdata; fetch second; stallreq_o high exactly 3 cycles; RESP lasts 1 cycle.
- Byte write: sel=4'b0010, wdata=32'h0000_AB00 -> mem_we_o=1, mem_sel_o=4'b0010 held until ack; ram_data_o unchanged.
- No ack, TIMEOUT_CYC=4 -> bus_err_o pulses once on the 4th wait cycle; read returns 32'h0; FSM reaches RESP.
- ram_ce_i dropped during the wait (flush) -> access completes; ram_data_o keeps its old value; fetch still served.
- rst=0 asserted while mem_req_o=1 -> mem_req_o and stallreq_o go 0 before the next edge; state=IDLE after release.
